// File: rtl/dwa_element_selector.sv
`default_nettype none
// ============================================================================
// Module      : dwa_element_selector
// Description : Data-weighted-averaging selector that turns a quantizer level
//               into unit-element enables for a thermometer DAC.
// Revision    : 1.0 - initial release
// ============================================================================
module dwa_element_selector #(
    parameter int INPUT_WIDTH  = 8,
    parameter int NUM_ELEMENTS = 16,
    parameter int PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic signed [INPUT_WIDTH-1:0] level_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          dwa_en_i,
    output logic [NUM_ELEMENTS-1:0]       sel_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [PTR_WIDTH-1:0]          ptr_o,
    output logic                          clip_o
);

    // One extra bit holds both L = NUM_ELEMENTS and pointer+level sums.
    localparam int c_lvl_w = PTR_WIDTH + 1;
    localparam logic [c_lvl_w-1:0]            c_num    = c_lvl_w'(NUM_ELEMENTS);
    localparam logic signed [INPUT_WIDTH-1:0] c_num_in = INPUT_WIDTH'(NUM_ELEMENTS);

    logic [NUM_ELEMENTS-1:0] r_sel;
    logic                    r_valid;
    logic [PTR_WIDTH-1:0]    r_ptr_out;
    logic                    r_clip;
    logic [PTR_WIDTH-1:0]    r_ptr;

    logic [c_lvl_w-1:0]      w_level;
    logic                    w_clip;
    logic [c_lvl_w-1:0]      w_base;
    logic [c_lvl_w-1:0]      w_off;
    logic [c_lvl_w-1:0]      w_sum;
    logic [PTR_WIDTH-1:0]    w_ptr_next;
    logic [NUM_ELEMENTS-1:0] w_sel;
    logic                    w_accept;

    always_comb begin
        w_level = '0;
        w_clip  = 1'b0;
        if (level_i[INPUT_WIDTH-1]) begin
            w_level = '0;
            w_clip  = 1'b1;
        end else if (level_i > c_num_in) begin
            w_level = c_num;
            w_clip  = 1'b1;
        end else begin
            w_level = c_lvl_w'(level_i);
        end
    end

    // Static mode builds the thermometer from element 0 without touching r_ptr.
    assign w_base = dwa_en_i ? {1'b0, r_ptr} : '0;

    // Element k is on when its circular distance from the base is below L.
    always_comb begin
        w_off = '0;
        w_sel = '0;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            if (c_lvl_w'(k) >= w_base) begin
                w_off = c_lvl_w'(k) - w_base;
            end else begin
                w_off = c_lvl_w'(k) + c_num - w_base;
            end
            w_sel[k] = (w_off < w_level);
        end
    end

    assign w_sum      = {1'b0, r_ptr} + w_level;
    assign w_ptr_next = (w_sum >= c_num) ? PTR_WIDTH'(w_sum - c_num)
                                         : w_sum[PTR_WIDTH-1:0];

    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_ptr_out <= '0;
            r_clip    <= 1'b0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_sel     <= w_sel;
            r_valid   <= 1'b1;
            r_ptr_out <= r_ptr;
            r_clip    <= w_clip;
            if (dwa_en_i) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign sel_o   = r_sel;
    assign valid_o = r_valid;
    assign ptr_o   = r_ptr_out;
    assign clip_o  = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_dwa_element_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwa_element_selector
// Description : Directed and randomized checks of dwa_element_selector against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwa_element_selector;

    localparam int N  = 16;
    localparam int IW = 8;
    localparam int PW = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic signed [IW-1:0] level_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic                 dwa_en_i = 1'b1;
    logic [N-1:0]         sel_o;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic [PW-1:0]        ptr_o;
    logic                 clip_o;

    dwa_element_selector #(
        .INPUT_WIDTH (IW),
        .NUM_ELEMENTS(N),
        .PTR_WIDTH   (PW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (level_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .dwa_en_i(dwa_en_i),
        .sel_o   (sel_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ptr_o   (ptr_o),
        .clip_o  (clip_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: output register contents and rotation pointer.
    bit       m_valid;
    bit [N-1:0] m_sel;
    int       m_ptr;
    bit       m_clip;
    int       m_L;
    int       m_p;
    bit       track_usage;
    int       usage [N];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_sel = '0; m_ptr = 0; m_clip = 0; m_L = 0; m_p = 0;
        for (int k = 0; k < N; k++) usage[k] = 0;
    endtask

    task automatic do_reset(input int lvl, input bit vi);
        rst_i   = 1'b0;
        valid_i = vi;
        level_i = IW'(lvl);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        model_reset();
        check_value("rst_valid", valid_o, 0);
        check_value("rst_sel", sel_o, 0);
        check_value("rst_ptr", ptr_o, 0);
        check_value("rst_clip", clip_o, 0);
        rst_i   = 1'b1;
        valid_i = 1'b0;
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic cycle(input int lvl, input bit vi, input bit en, input bit ri);
        bit accept;
        bit transfer;
        int L;
        int lo;
        int hi;
        level_i  = IW'(lvl);
        valid_i  = vi;
        dwa_en_i = en;
        ready_i  = ri;
        #1;
        check_value("ready_o", ready_o, (!m_valid || ri) ? 1 : 0);
        accept   = vi && (!m_valid || ri);
        transfer = m_valid && ri;
        if (transfer && track_usage) begin
            for (int k = 0; k < N; k++) usage[k] += sel_o[k];
            lo = usage[0];
            hi = usage[0];
            for (int k = 1; k < N; k++) begin
                if (usage[k] < lo) lo = usage[k];
                if (usage[k] > hi) hi = usage[k];
            end
            check_value("usage_spread_le1", (hi - lo <= 1) ? 1 : 0, 1);
        end
        if (accept) begin
            L = (lvl < 0) ? 0 : (lvl > N) ? N : lvl;
            m_clip = (lvl < 0) || (lvl > N);
            m_sel  = '0;
            for (int j = 0; j < L; j++) m_sel[((en ? m_p : 0) + j) % N] = 1'b1;
            m_ptr   = m_p;
            m_L     = L;
            m_valid = 1;
            if (en) m_p = (m_p + L) % N;
        end else if (transfer) begin
            m_valid = 0;
        end
        @(posedge clk_i);
        #1;
        check_value("valid_o", valid_o, m_valid);
        if (m_valid) begin
            check_value("sel_o", sel_o, m_sel);
            check_value("ptr_o", ptr_o, m_ptr);
            check_value("clip_o", clip_o, m_clip);
            check_value("popcount", $countones(sel_o), m_L);
        end
    endtask

    initial begin
        track_usage = 0;
        model_reset();

        // Rotation across the wrap point.
        do_reset(0, 0);
        cycle(5, 1, 1, 1);
        check_value("seq_sel0", sel_o, 32'h001F);
        cycle(7, 1, 1, 1);
        check_value("seq_sel1", sel_o, 32'h0FE0);
        check_value("seq_ptr1", ptr_o, 5);
        cycle(6, 1, 1, 1);
        check_value("seq_sel2", sel_o, 32'hF003);
        check_value("seq_ptr2", ptr_o, 12);
        check_value("seq_clip2", clip_o, 0);
        cycle(1, 1, 1, 1);
        check_value("seq_ptr_end", ptr_o, 2);

        // Clamping with pointer at 3.
        do_reset(0, 0);
        cycle(3, 1, 1, 1);
        cycle(-3, 1, 1, 1);
        check_value("clamp_lo_sel", sel_o, 32'h0000);
        check_value("clamp_lo_clip", clip_o, 1);
        cycle(20, 1, 1, 1);
        check_value("clamp_hi_sel", sel_o, 32'hFFFF);
        check_value("clamp_hi_clip", clip_o, 1);
        check_value("clamp_hi_ptr", ptr_o, 3);
        cycle(16, 1, 1, 1);
        check_value("full_sel", sel_o, 32'hFFFF);
        check_value("full_clip", clip_o, 0);
        cycle(1, 1, 1, 1);
        check_value("full_ptr_kept", ptr_o, 3);

        // Backpressure.
        do_reset(0, 0);
        cycle(4, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(2, 1, 1, 0);
            check_value("bp_sel_hold", sel_o, 32'h000F);
        end
        cycle(2, 1, 1, 1);
        check_value("bp_next_sel", sel_o, 32'h0030);
        check_value("bp_next_ptr", ptr_o, 4);

        // Static mode keeps the pointer.
        do_reset(0, 0);
        cycle(5, 1, 1, 1);
        cycle(4, 1, 1, 1);
        cycle(3, 1, 0, 1);
        check_value("static_sel", sel_o, 32'h0007);
        check_value("static_ptr", ptr_o, 9);
        cycle(3, 1, 1, 1);
        check_value("resume_sel", sel_o, 32'h0E00);

        // Reset mid-stream, with a competing accept.
        do_reset(0, 0);
        cycle(9, 1, 1, 1);
        do_reset(7, 1);
        cycle(4, 1, 1, 1);
        check_value("post_rst_sel", sel_o, 32'h000F);

        // Random mixed traffic, including clamping and static mode.
        do_reset(0, 0);
        for (int i = 0; i < 4000; i++) begin
            cycle(int'($urandom_range(0, 32)) - 8, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
        end

        // Random DWA traffic without clamping: usage must stay balanced.
        do_reset(0, 0);
        track_usage = 1;
        for (int i = 0; i < 6000; i++) begin
            cycle(int'($urandom_range(0, N)), ($urandom_range(0, 3) != 0), 1'b1,
                  $urandom_range(0, 1) == 1);
        end
        track_usage = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dwa_element_selector.md
Name: dwa_element_selector

Overview:
- Downstream neighbour of the quantizer: consumes the registered quantizer level and drives the unit-element enables of the thermometer DAC array.
- Uses data-weighted averaging (DWA): a rotating pointer spreads element usage so static element mismatch is first-order noise-shaped.
- Registered output stage with valid/ready handshake so the DAC driver can stall the stream.

Parameters:
- INPUT_WIDTH, 8, width of the signed level input; matches the quantizer output width.
- NUM_ELEMENTS, 16, number of unit DAC elements; any value 2..64, power of two not required.
- PTR_WIDTH, $clog2(NUM_ELEMENTS), width of the rotation pointer.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-low reset.
- level_i  input  INPUT_WIDTH (signed)  quantized level from the quantizer.
- valid_i  input  1  level_i is valid this cycle.
- ready_o  output  1  block can accept level_i this cycle.
- dwa_en_i  input  1  1 = DWA rotation; 0 = static thermometer from element 0.
- sel_o  output  NUM_ELEMENTS  element enables; bit k drives unit element k.
- valid_o  output  1  sel_o, ptr_o and clip_o are valid.
- ready_i  input  1  downstream accepts the current output.
- ptr_o  output  PTR_WIDTH  pointer value used to build the current sel_o (debug/verification).
- clip_o  output  1  current sel_o came from a clamped level.

Behaviour:
- Reset (rst_i low at a clock edge): sel_o=0, valid_o=0, ptr_o=0, clip_o=0, internal pointer=0. Reset overrides any simultaneous transfer; an in-flight output is discarded.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational; single output register, no skid buffer).
  - Accept occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
  - On accept: output register loads, valid_o=1 next cycle.
  - On transfer without accept: valid_o=0 next cycle.
  - While valid_o && !ready_i: sel_o, ptr_o and clip_o hold; internal pointer holds.
- Latency: 1 cycle from accept to valid_o.
- Clamp: L = 0 if level_i<0; L = NUM_ELEMENTS if level_i>NUM_ELEMENTS; else L = level_i. clip_o=1 when either clamp applied.
- Selection when dwa_en_i=1, pointer p:
  - Bits p, p+1, …, p+L-1 (mod NUM_ELEMENTS) are 1; all others 0.
  - ptr_o = p.
  - Next p = p+L, minus NUM_ELEMENTS if the sum is ≥ NUM_ELEMENTS. Compute in PTR_WIDTH+1 bits; no modulo operator.
- Selection when dwa_en_i=0: bits 0..L-1 are 1; ptr_o = current p; pointer holds (not reset). Re-enabling dwa_en_i resumes rotation from the held p.
- Boundaries:
  - L=0: sel_o all zeros, pointer unchanged.
  - L=NUM_ELEMENTS: sel_o all ones, pointer unchanged (full wrap).
  - p+L exactly equal to NUM_ELEMENTS: next p = 0.
  - Pointer updates only on accept.
  - dwa_en_i is sampled only on accept.
- Invariant: popcount(sel_o) == L whenever valid_o=1.

Test Plan (NUM_ELEMENTS=16, INPUT_WIDTH=8, ready_i=1 unless stated):
- Reset, dwa_en_i=1, levels 5, 7, 6 on consecutive cycles -> sel_o = 0x001F (ptr_o 0), 0x0FE0 (ptr_o 5), 0xF003 (ptr_o 12); internal pointer ends at 2; clip_o=0 throughout.
- Clamping with pointer at 3: level -3 -> sel_o=0x0000, clip_o=1; then level 20 -> sel_o=0xFFFF, clip_o=1; ptr_o stays 3 for both; then level 16 -> sel_o=0xFFFF, clip_o=0.
- Backpressure: accept level 4, then hold ready_i low 3 cycles with valid_i high -> ready_o=0 for those cycles; sel_o=0x000F held; pointer stays 4; on ready_i high, the next level 2 yields 0x0030.
- Static mode: pointer at 9, dwa_en_i=0, level 3 -> sel_o=0x0007, ptr_o=9, pointer stays 9; then dwa_en_i=1, level 3 -> sel_o=0x0E00.
- Reset mid-stream: pointer at 9 with valid_o=1, drive rst_i low for 1 cycle -> next cycle sel_o=0, valid_o=0, ptr_o=0; then level 4 -> sel_o=0x000F.
- Random: 10k random levels in -8..24 with random ready_i -> popcount(sel_o) equals clamped L; no output changes while stalled; with dwa_en_i=1 and no clamping, cumulative per-element usage counts differ by at most 1 at every transfer.
